// File: rtl/serial_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// serial_tx_arbiter_if
// Bundle of the request-side handshake and the serial-line status outputs of
// serial_tx_arbiter.
//   enable     : master -> arbiter, allows new grants
//   req_valid  : master -> arbiter, one bit per requester
//   req_data   : master -> arbiter, requester i word at [7*i+6:7*i]
//   req_ready  : arbiter -> master, one-hot accept (combinational)
//   serial_out : arbiter -> line, idles high
//   busy       : arbiter -> master, frame in flight
//   grant_id   : arbiter -> master, index of the current/last granted requester
//   tx_done    : arbiter -> master, one-cycle pulse after a frame
// ---------------------------------------------------------------------------
interface serial_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic                 enable;
  logic [N_REQ-1:0]     req_valid;
  logic [7*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]     req_ready;
  logic                 serial_out;
  logic                 busy;
  logic [2:0]           grant_id;
  logic                 tx_done;

  modport master (
    output enable, req_valid, req_data,
    input  req_ready, serial_out, busy, grant_id, tx_done
  );

  modport slave (
    input  enable, req_valid, req_data,
    output req_ready, serial_out, busy, grant_id, tx_done
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// ---------------------------------------------------------------------------
// serial_tx_arbiter
// Round-robin arbiter sharing one serial line between N_REQ requesters.
// Each accepted 7-bit word is framed as: start (0), d0..d6 LSB first,
// even-parity bit, then STOP_BITS high stop cycles. One frame at a time.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : serial_tx_arbiter_if.slave (requests in, line and status out)
// ---------------------------------------------------------------------------
module serial_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int STOP_BITS = 1
) (
  input  logic               clk,
  input  logic               rstn,
  serial_tx_arbiter_if.slave bus
);
  localparam int DATA_W = 7;
  localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DATA_W:0]   shift_q, shift_d;     // {parity, word}, shifted out LSB first
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [STOP_W-1:0] stop_cnt_q, stop_cnt_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        grant_q, grant_d;
  logic              serial_q, serial_d;
  logic              done_q, done_d;

  logic              any_hi, any_all, can_grant;
  logic [2:0]        idx_hi, idx_all, pick;
  logic [N_REQ-1:0]  ready;
  logic [DATA_W-1:0] pick_data;

  // Bit that makes the 8 transmitted bits (word + parity) XOR to zero.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Round-robin search: lowest valid index at or above the pointer wins;
  // if none, wrap around to the lowest valid index overall.
  always_comb begin
    any_hi  = 1'b0;
    idx_hi  = '0;
    any_all = 1'b0;
    idx_all = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        any_all = 1'b1;
        idx_all = 3'(i);
        if (3'(i) >= ptr_q) begin
          any_hi = 1'b1;
          idx_hi = 3'(i);
        end
      end
    end
    pick = any_hi ? idx_hi : idx_all;
  end

  // rstn is included so req_ready stays low while reset is held.
  assign can_grant = rstn && bus.enable && (state_q == S_IDLE) && any_all;

  always_comb begin
    ready     = '0;
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) == pick) begin
        ready[i]  = can_grant;
        pick_data = bus.req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.serial_out = serial_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.grant_id   = grant_q;
  assign bus.tx_done    = done_q;

  // serial_d is the line value for the next cycle; it defaults to idle-high.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    serial_d   = 1'b1;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_grant) begin
          shift_d  = {even_parity(pick_data), pick_data};
          grant_d  = pick;
          ptr_d    = (pick == 3'(N_REQ - 1)) ? 3'd0 : pick + 3'd1;
          serial_d = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        serial_d  = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = 3'd0;
        state_d   = S_DATA;
      end
      S_DATA: begin
        if (bit_cnt_q == 3'd7) begin
          stop_cnt_d = '0;
          state_d    = S_STOP;
        end else begin
          serial_d  = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      S_STOP: begin
        if (stop_cnt_q == STOP_W'(STOP_BITS - 1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + STOP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      serial_q   <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      serial_q   <= serial_d;
      done_q     <= done_d;
    end
  end

  // Shift register is only meaningful after an accept, so it carries no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end
endmodule
